// File: rtl/gmul_uni_pkg.sv
// Shared types and defaults for the unipolar unary multiplier controller.
//   gmul_ctrl_state_t : sequencer states IDLE -> LOAD -> RUN -> DONE
//   DEF_DATAWD        : default operand width (matches the multiplier build)
//   DEF_STREAM_LOG2   : default log2 of the stream window (full Sobol period)
//   DEF_STREAM_LEN    : default window length in cycles
package gmul_uni_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} gmul_ctrl_state_t;

  localparam int DEF_DATAWD      = 8;
  localparam int DEF_STREAM_LOG2 = DEF_DATAWD;
  localparam int DEF_STREAM_LEN  = 1 << DEF_STREAM_LOG2;

  // Window length for an arbitrary log2 size.
  function automatic int stream_len(input int log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/unary_ones_cnt.sv
// Ones counter for a unary bit stream. Reusable by any unary result decoder.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : accumulate bit_in this cycle
//   bit_in     : unary stream bit
//   cnt        : running ones count
module unary_ones_cnt #(
  parameter int CNTW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            bit_in,
  output logic [CNTW-1:0] cnt
);

  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + CNTW'(bit_in);
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/gmul_uni_ctrl.sv
// Sequencer for one unipolar unary multiplier (gMUL_uni).
//   clk, rst_n            : clock, async active-low reset (shared with the multiplier)
//   in_valid/in_ready     : operand request handshake
//   in_a, in_b            : operands (unipolar, value/2^DATAWD)
//   in_ld_a, in_ld_b      : 1 = load the new operand, 0 = reuse the buffered one
//   mul_iA/mul_iB         : operand buses to the multiplier
//   mul_loadA/mul_loadB   : one-cycle load strobes to the multiplier
//   mul_oC                : unary product stream from the multiplier
//   out_valid/out_ready   : result handshake
//   out_cnt               : ones counted over a 2^STREAM_LOG2 cycle window
//   busy                  : controller is not idle
module gmul_uni_ctrl
  import gmul_uni_pkg::*;
#(
  parameter int DATAWD      = DEF_DATAWD,
  parameter int STREAM_LOG2 = DATAWD,
  parameter int CNTW        = STREAM_LOG2 + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATAWD-1:0] in_a,
  input  logic [DATAWD-1:0] in_b,
  input  logic              in_ld_a,
  input  logic              in_ld_b,
  output logic [DATAWD-1:0] mul_iA,
  output logic [DATAWD-1:0] mul_iB,
  output logic              mul_loadA,
  output logic              mul_loadB,
  input  logic              mul_oC,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNTW-1:0]   out_cnt,
  output logic              busy
);

  gmul_ctrl_state_t        state_q;
  logic [STREAM_LOG2-1:0]  win_q;
  logic                    in_ready_q, out_valid_q;
  logic                    loadA_q, loadB_q;
  logic [DATAWD-1:0]       iA_q, iB_q;

  // Operand buses and strobes are registered at accept, so they present
  // during the LOAD cycle and the multiplier buffers are valid from RUN on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      loadA_q     <= 1'b0;
      loadB_q     <= 1'b0;
      iA_q        <= '0;
      iB_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            iA_q       <= in_a;
            iB_q       <= in_b;
            loadA_q    <= in_ld_a;
            loadB_q    <= in_ld_b;
            in_ready_q <= 1'b0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          loadA_q <= 1'b0;
          loadB_q <= 1'b0;
          win_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          win_q <= win_q + 1'b1;  // wraps back to 0 after the last cycle
          if (win_q == {STREAM_LOG2{1'b1}}) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Ready comes back only in IDLE: no accept in the drain cycle.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  unary_ones_cnt #(.CNTW(CNTW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == LOAD),
    .en     (state_q == RUN),
    .bit_in (mul_oC),
    .cnt    (out_cnt)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mul_iA    = iA_q;
  assign mul_iB    = iB_q;
  assign mul_loadA = loadA_q;
  assign mul_loadB = loadB_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gmul_uni_ctrl.sv
// Bench for gmul_uni_ctrl with a behavioural correlated-Sobol multiplier attached.
module tb_gmul_uni_ctrl;

  localparam int DW = 8;
  localparam int SL = 8;
  localparam int CW = SL + 1;
  localparam int LAT = (1 << SL) + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_ld_a, in_ld_b;
  logic [DW-1:0] in_a, in_b, mul_iA, mul_iB;
  logic          mul_loadA, mul_loadB, mul_oC;
  logic          out_valid, out_ready, busy;
  logic [CW-1:0] out_cnt;

  always #5 clk = ~clk;

  gmul_uni_ctrl #(.DATAWD(DW), .STREAM_LOG2(SL), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ld_a(in_ld_a), .in_ld_b(in_ld_b),
    .mul_iA(mul_iA), .mul_iB(mul_iB), .mul_loadA(mul_loadA), .mul_loadB(mul_loadB),
    .mul_oC(mul_oC),
    .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt), .busy(busy)
  );

  // Multiplier model: operand buffers plus one free-running van der Corput
  // sequence shared by both comparators (fully correlated -> min(A,B)).
  logic [DW-1:0] bufA, bufB, rng, sob;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bufA <= '0; bufB <= '0; rng <= '0;
    end else begin
      if (mul_loadA) bufA <= mul_iA;
      if (mul_loadB) bufB <= mul_iB;
      rng <= rng + 1'b1;
    end
  end
  always_comb begin
    sob = '0;
    for (int i = 0; i < DW; i++) sob[i] = rng[DW-1-i];
  end
  assign mul_oC = (bufA > sob) && (bufB > sob);

  // Scoreboard state (all owned by the initial block below)
  int        n_chk = 0, n_err = 0, cyc = 0;
  int        exp_q[$], acc_q[$];
  int        shA = 0, shB = 0;
  int        la_n = 0, lb_n = 0, done_n = 0;
  bit        last_acc = 0, prev_ov = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: sample the current cycle (inputs as the coming edge sees
  // them), update the scoreboard, then step past the edge.
  task automatic tick();
    int e;
    bit hs_in, hs_out;
    hs_in  = rst_n && in_valid && in_ready;
    hs_out = rst_n && out_valid && out_ready;
    if (!rst_n) begin
      exp_q.delete(); acc_q.delete();
      shA = 0; shB = 0; prev_ov = 0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() > 0) chk("latency", cyc - acc_q[0], LAT);
        else                  chk("spurious_out_valid", out_valid, 0);
      end
      if (hs_out && exp_q.size() > 0) begin
        chk("out_cnt", out_cnt, exp_q.pop_front());
        void'(acc_q.pop_front());
        done_n++;
      end
      if (hs_in) begin
        if (in_ld_a) shA = in_a;
        if (in_ld_b) shB = in_b;
        e = (shA < shB) ? shA : shB;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
      end
      la_n += mul_loadA;
      lb_n += mul_loadB;
      prev_ov = out_valid;
    end
    last_acc = hs_in;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic submit(input int a, input int b, input bit la, input bit lb);
    int k = 0;
    in_valid = 1'b1; in_a = DW'(a); in_b = DW'(b); in_ld_a = la; in_ld_b = lb;
    do begin tick(); k++; end while (!last_acc && k < 600);
    chk("accepted", last_acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int d0 = done_n;
    int k  = 0;
    while (done_n == d0 && k < 600) begin tick(); k++; end
    chk("job_done", done_n - d0, 1);
  endtask

  task automatic job(input int a, input int b, input bit la, input bit lb,
                     input int exp_la, input int exp_lb);
    int a0 = la_n;
    int b0 = lb_n;
    submit(a, b, la, lb);
    wait_done();
    chk("strobeA", la_n - a0, exp_la);
    chk("strobeB", lb_n - b0, exp_lb);
  endtask

  initial begin
    int k, ovc;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_ld_a = 1'b0; in_ld_b = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_iA", mul_iA, 0);
    chk("idle_iB", mul_iB, 0);
    chk("idle_loadA", mul_loadA, 0);
    chk("idle_loadB", mul_loadB, 0);
    chk("idle_cnt", out_cnt, 0);

    job(8'hFF, 8'hFF, 1, 1, 1, 1);   // 255
    job(8'h00, 8'hFF, 1, 1, 1, 1);   // 0
    job(8'h80, 8'h40, 1, 1, 1, 1);   // 64
    job(8'h00, 8'h20, 0, 1, 0, 1);   // reuse A=0x80 -> 32, issued right after drain
    job(8'h11, 8'h22, 0, 0, 0, 0);   // reuse both -> 32

    // Result held in DONE with a pending request
    out_ready = 1'b0;
    submit(8'h30, 8'h50, 1, 1);
    k = 0;
    while (!out_valid && k < 400) begin tick(); k++; end
    chk("hold_ov_seen", out_valid, 1);
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h00; in_ld_a = 1'b1; in_ld_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_cnt", out_cnt, 8'h30);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();                            // drain cycle
    chk("no_accept_in_done", last_acc, 0);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_out_valid", out_valid, 0);
    tick();
    chk("accept_after_drain", last_acc, 1);
    in_valid = 1'b0;
    wait_done();                       // 0xFF vs 0x00 -> 0

    // Reset in the middle of RUN
    submit(8'h60, 8'h70, 1, 1);
    repeat (50) tick();
    chk("midrun_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    ovc = 0;
    for (int i = 0; i < 300; i++) begin tick(); ovc += out_valid; end
    chk("no_out_after_rst", ovc, 0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_iA", mul_iA, 0);
    job(8'h55, 8'hAA, 1, 1, 1, 1);   // 85
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
